// File: rtl/bru_fwd_hazard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bru_fwd_hazard : BRU decode/execute slot, WB->EX forwarding, load-use stall
// Revision 1.0
// ----------------------------------------------------------------------------
module bru_fwd_hazard (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  ixu1_dc_rs1,
  input  logic [4:0]  ixu1_dc_rs2,
  input  logic [4:0]  ixu2_dc_rs1,
  input  logic [4:0]  ixu2_dc_rs2,
  input  logic [4:0]  lsu_dc_rs1,
  input  logic [4:0]  lsu_dc_rs2,
  input  logic [4:0]  lsu_ex_rd,
  input  logic        lsu_ex_is_load,
  input  logic [4:0]  ixu1_wb_rd,
  input  logic [4:0]  ixu2_wb_rd,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] ixu1_wb_data,
  input  logic [31:0] ixu2_wb_data,
  input  logic [31:0] lsu_wb_data,
  input  logic        ixu1_wb_nop,
  input  logic        ixu2_wb_nop,
  input  logic        lsu_wb_nop,
  input  logic        lsu_wb_is_load,
  input  logic [4:0]  ixu1_ex_rs1,
  input  logic [4:0]  ixu1_ex_rs2,
  input  logic [4:0]  ixu2_ex_rs1,
  input  logic [4:0]  ixu2_ex_rs2,
  input  logic [4:0]  lsu_ex_rs1,
  input  logic [4:0]  lsu_ex_rs2,
  output logic        stall,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [31:0] ex_pc_out,
  output logic [4:0]  rd_out,
  output logic [31:0] ret_addr,
  output logic        reg_file_wr_en,
  output logic        branch_taken,
  output logic [31:0] new_pc,
  output logic        halt_proc,
  output logic        ixu1_rs1_fwd,
  output logic        ixu1_rs2_fwd,
  output logic        ixu2_rs1_fwd,
  output logic        ixu2_rs2_fwd,
  output logic        lsu_rs1_fwd,
  output logic        lsu_rs2_fwd,
  output logic [31:0] ixu1_rs1_fwd_data,
  output logic [31:0] ixu1_rs2_fwd_data,
  output logic [31:0] ixu2_rs1_fwd_data,
  output logic [31:0] ixu2_rs2_fwd_data,
  output logic [31:0] lsu_rs1_fwd_data,
  output logic [31:0] lsu_rs2_fwd_data
);

  localparam logic [31:0] c_nop       = 32'h0000_0013;
  localparam logic [31:0] c_ecall     = 32'h0000_0073;
  localparam logic [31:0] c_ebreak    = 32'h0010_0073;
  localparam logic [6:0]  c_op_jal    = 7'b1101111;
  localparam logic [6:0]  c_op_jalr   = 7'b1100111;
  localparam logic [6:0]  c_op_branch = 7'b1100011;
  localparam logic [31:0] c_bundle    = 32'd16;

  logic [31:0] d_inst_q, d_inst_d, d_pc_q, d_pc_d;
  logic [31:0] e_inst_q, e_inst_d, e_pc_q, e_pc_d;

  // Only branches and JALR actually read registers; others report x0.
  function automatic logic [4:0] src_rs1(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    src_rs1 = (op == c_op_branch || op == c_op_jalr) ? i[19:15] : 5'd0;
  endfunction

  function automatic logic [4:0] src_rs2(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    src_rs2 = (op == c_op_branch) ? i[24:20] : 5'd0;
  endfunction

  // Returns {fwd, data}; the LSU only forwards load results.
  function automatic logic [32:0] fwd_sel(
    input logic [4:0]  s,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  r3,
    input logic        n1,
    input logic        n2,
    input logic        n3,
    input logic        ld,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] d3
  );
    fwd_sel = 33'd0;
    if (s != 5'd0) begin
      if (!n3 && ld && r3 == s)  fwd_sel = {1'b1, d3};
      else if (!n2 && r2 == s)   fwd_sel = {1'b1, d2};
      else if (!n1 && r1 == s)   fwd_sel = {1'b1, d1};
    end
  endfunction

  logic [4:0]  w_d_rs1, w_d_rs2, w_e_rs1, w_e_rs2;
  logic        w_stall;
  logic [32:0] w_f_ixu1_rs1, w_f_ixu1_rs2, w_f_ixu2_rs1, w_f_ixu2_rs2;
  logic [32:0] w_f_lsu_rs1, w_f_lsu_rs2, w_f_bru_rs1, w_f_bru_rs2;

  assign w_d_rs1 = src_rs1(d_inst_q);
  assign w_d_rs2 = src_rs2(d_inst_q);
  assign w_e_rs1 = src_rs1(e_inst_q);
  assign w_e_rs2 = src_rs2(e_inst_q);

  assign w_stall = lsu_ex_is_load && (lsu_ex_rd != 5'd0) &&
                   ((lsu_ex_rd == ixu1_dc_rs1) || (lsu_ex_rd == ixu1_dc_rs2) ||
                    (lsu_ex_rd == ixu2_dc_rs1) || (lsu_ex_rd == ixu2_dc_rs2) ||
                    (lsu_ex_rd == lsu_dc_rs1)  || (lsu_ex_rd == lsu_dc_rs2)  ||
                    (lsu_ex_rd == w_d_rs1)     || (lsu_ex_rd == w_d_rs2));

  assign w_f_ixu1_rs1 = fwd_sel(ixu1_ex_rs1, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_ixu1_rs2 = fwd_sel(ixu1_ex_rs2, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_ixu2_rs1 = fwd_sel(ixu2_ex_rs1, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_ixu2_rs2 = fwd_sel(ixu2_ex_rs2, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_lsu_rs1  = fwd_sel(lsu_ex_rs1, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_lsu_rs2  = fwd_sel(lsu_ex_rs2, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_bru_rs1  = fwd_sel(w_e_rs1, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);
  assign w_f_bru_rs2  = fwd_sel(w_e_rs2, ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd, ixu1_wb_nop,
                                ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load, ixu1_wb_data,
                                ixu2_wb_data, lsu_wb_data);

  logic [31:0] w_op1, w_op2, w_imm_i, w_imm_b, w_imm_j, w_target, w_link_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_taken, w_link;

  assign w_op1     = w_f_bru_rs1[32] ? w_f_bru_rs1[31:0] : rs1_data;
  assign w_op2     = w_f_bru_rs2[32] ? w_f_bru_rs2[31:0] : rs2_data;
  assign w_opcode  = e_inst_q[6:0];
  assign w_funct3  = e_inst_q[14:12];
  assign w_rd      = e_inst_q[11:7];
  assign w_imm_i   = {{21{e_inst_q[31]}}, e_inst_q[30:20]};
  assign w_imm_b   = {{20{e_inst_q[31]}}, e_inst_q[7], e_inst_q[30:25], e_inst_q[11:8], 1'b0};
  assign w_imm_j   = {{12{e_inst_q[31]}}, e_inst_q[19:12], e_inst_q[20], e_inst_q[30:21], 1'b0};
  assign w_link_pc = e_pc_q + c_bundle;

  always_comb begin
    w_taken  = 1'b0;
    w_link   = 1'b0;
    w_target = w_link_pc;
    case (w_opcode)
      c_op_jal: begin
        w_taken  = 1'b1;
        w_link   = 1'b1;
        w_target = e_pc_q + w_imm_j;
      end
      c_op_jalr: begin
        w_taken  = 1'b1;
        w_link   = 1'b1;
        w_target = (w_op1 + w_imm_i) & ~32'd1;
      end
      c_op_branch: begin
        case (w_funct3)
          3'b000:  w_taken = (w_op1 == w_op2);
          3'b001:  w_taken = (w_op1 != w_op2);
          3'b100:  w_taken = ($signed(w_op1) <  $signed(w_op2));
          3'b101:  w_taken = ($signed(w_op1) >= $signed(w_op2));
          3'b110:  w_taken = (w_op1 <  w_op2);
          3'b111:  w_taken = (w_op1 >= w_op2);
          default: w_taken = 1'b0;
        endcase
        if (w_taken) w_target = e_pc_q + w_imm_b;
      end
      default: ;
    endcase
  end

  // A redirect squashes both stages; otherwise a stall freezes D and bubbles E.
  always_comb begin
    d_inst_d = d_inst_q;
    d_pc_d   = d_pc_q;
    e_inst_d = e_inst_q;
    e_pc_d   = e_pc_q;
    if (w_taken) begin
      d_inst_d = c_nop;
      d_pc_d   = 32'd0;
      e_inst_d = c_nop;
      e_pc_d   = 32'd0;
    end else if (w_stall) begin
      e_inst_d = c_nop;
      e_pc_d   = 32'd0;
    end else begin
      d_inst_d = inst;
      d_pc_d   = inst_pc;
      e_inst_d = d_inst_q;
      e_pc_d   = d_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_inst_q <= c_nop;
      d_pc_q   <= 32'd0;
      e_inst_q <= c_nop;
      e_pc_q   <= 32'd0;
    end else begin
      d_inst_q <= d_inst_d;
      d_pc_q   <= d_pc_d;
      e_inst_q <= e_inst_d;
      e_pc_q   <= e_pc_d;
    end
  end

  assign stall             = w_stall;
  assign rs1_out           = w_e_rs1;
  assign rs2_out           = w_e_rs2;
  assign ex_pc_out         = e_pc_q;
  assign branch_taken      = w_taken;
  assign new_pc            = w_target;
  assign ret_addr          = w_link ? w_link_pc : 32'd0;
  assign rd_out            = w_link ? w_rd : 5'd0;
  assign reg_file_wr_en    = w_link && (w_rd != 5'd0);
  assign halt_proc         = (e_inst_q == c_ecall) || (e_inst_q == c_ebreak);

  assign ixu1_rs1_fwd      = w_f_ixu1_rs1[32];
  assign ixu1_rs2_fwd      = w_f_ixu1_rs2[32];
  assign ixu2_rs1_fwd      = w_f_ixu2_rs1[32];
  assign ixu2_rs2_fwd      = w_f_ixu2_rs2[32];
  assign lsu_rs1_fwd       = w_f_lsu_rs1[32];
  assign lsu_rs2_fwd       = w_f_lsu_rs2[32];
  assign ixu1_rs1_fwd_data = w_f_ixu1_rs1[31:0];
  assign ixu1_rs2_fwd_data = w_f_ixu1_rs2[31:0];
  assign ixu2_rs1_fwd_data = w_f_ixu2_rs1[31:0];
  assign ixu2_rs2_fwd_data = w_f_ixu2_rs2[31:0];
  assign lsu_rs1_fwd_data  = w_f_lsu_rs1[31:0];
  assign lsu_rs2_fwd_data  = w_f_lsu_rs2[31:0];

endmodule
`default_nettype wire

// File: tb/tb_bru_fwd_hazard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bru_fwd_hazard : directed vector bench for bru_fwd_hazard
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_bru_fwd_hazard;

  localparam logic [31:0] c_nop = 32'h0000_0013;
  localparam logic [31:0] c_d1  = 32'h1111_1111;
  localparam logic [31:0] c_d2  = 32'h2222_2222;
  localparam logic [31:0] c_d3  = 32'h3333_3333;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, inst_pc, rs1_data, rs2_data;
  logic [4:0]  dc_src [6];
  logic [4:0]  ex_src [6];
  logic [4:0]  lsu_ex_rd;
  logic        lsu_ex_is_load;
  logic [4:0]  ixu1_wb_rd, ixu2_wb_rd, lsu_wb_rd;
  logic [31:0] ixu1_wb_data, ixu2_wb_data, lsu_wb_data;
  logic        ixu1_wb_nop, ixu2_wb_nop, lsu_wb_nop, lsu_wb_is_load;
  logic        stall, reg_file_wr_en, branch_taken, halt_proc;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [31:0] ex_pc_out, ret_addr, new_pc;
  logic [5:0]  f_flag;
  logic [31:0] f_data [6];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bru_fwd_hazard dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_pc(inst_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ixu1_dc_rs1(dc_src[0]), .ixu1_dc_rs2(dc_src[1]),
    .ixu2_dc_rs1(dc_src[2]), .ixu2_dc_rs2(dc_src[3]),
    .lsu_dc_rs1(dc_src[4]), .lsu_dc_rs2(dc_src[5]),
    .lsu_ex_rd(lsu_ex_rd), .lsu_ex_is_load(lsu_ex_is_load),
    .ixu1_wb_rd(ixu1_wb_rd), .ixu2_wb_rd(ixu2_wb_rd), .lsu_wb_rd(lsu_wb_rd),
    .ixu1_wb_data(ixu1_wb_data), .ixu2_wb_data(ixu2_wb_data), .lsu_wb_data(lsu_wb_data),
    .ixu1_wb_nop(ixu1_wb_nop), .ixu2_wb_nop(ixu2_wb_nop), .lsu_wb_nop(lsu_wb_nop),
    .lsu_wb_is_load(lsu_wb_is_load),
    .ixu1_ex_rs1(ex_src[0]), .ixu1_ex_rs2(ex_src[1]),
    .ixu2_ex_rs1(ex_src[2]), .ixu2_ex_rs2(ex_src[3]),
    .lsu_ex_rs1(ex_src[4]), .lsu_ex_rs2(ex_src[5]),
    .stall(stall), .rs1_out(rs1_out), .rs2_out(rs2_out), .ex_pc_out(ex_pc_out),
    .rd_out(rd_out), .ret_addr(ret_addr), .reg_file_wr_en(reg_file_wr_en),
    .branch_taken(branch_taken), .new_pc(new_pc), .halt_proc(halt_proc),
    .ixu1_rs1_fwd(f_flag[0]), .ixu1_rs2_fwd(f_flag[1]),
    .ixu2_rs1_fwd(f_flag[2]), .ixu2_rs2_fwd(f_flag[3]),
    .lsu_rs1_fwd(f_flag[4]), .lsu_rs2_fwd(f_flag[5]),
    .ixu1_rs1_fwd_data(f_data[0]), .ixu1_rs2_fwd_data(f_data[1]),
    .ixu2_rs1_fwd_data(f_data[2]), .ixu2_rs2_fwd_data(f_data[3]),
    .lsu_rs1_fwd_data(f_data[4]), .lsu_rs2_fwd_data(f_data[5])
  );

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [12:0] imm);
    enc_b = {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] r1,
                                           input logic [11:0] imm);
    enc_jalr = {imm, r1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        tk;
    logic [31:0] npc;
    logic [31:0] ret;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } br_vec_t;

  typedef struct packed {
    logic [4:0]  s;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic [4:0]  rd3;
    logic        n1;
    logic        n2;
    logic        n3;
    logic        ld;
    logic        fwd;
    logic [31:0] data;
  } fw_vec_t;

  typedef struct packed {
    logic        ld;
    logic [4:0]  exrd;
    logic [2:0]  idx;
    logic [4:0]  src;
    logic        exp;
  } st_vec_t;

  br_vec_t bv [14];
  fw_vec_t fv [10];
  st_vec_t sv [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bv[0]  = '{enc_b(3'b000, 5'd1, 5'd2, 13'd32), 32'h40, 32'd3, 32'd3, 1'b1, 32'h60, 32'h0, 5'd0, 1'b0, 5'd1, 5'd2};
    bv[1]  = '{enc_b(3'b000, 5'd1, 5'd2, 13'd32), 32'h40, 32'd3, 32'd4, 1'b0, 32'h50, 32'h0, 5'd0, 1'b0, 5'd1, 5'd2};
    bv[2]  = '{enc_b(3'b100, 5'd1, 5'd2, 13'd32), 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h60, 32'h0, 5'd0, 1'b0, 5'd1, 5'd2};
    bv[3]  = '{enc_b(3'b110, 5'd1, 5'd2, 13'd32), 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h50, 32'h0, 5'd0, 1'b0, 5'd1, 5'd2};
    bv[4]  = '{enc_b(3'b001, 5'd3, 5'd4, 13'h1FF0), 32'h40, 32'd3, 32'd4, 1'b1, 32'h30, 32'h0, 5'd0, 1'b0, 5'd3, 5'd4};
    bv[5]  = '{enc_b(3'b101, 5'd7, 5'd8, 13'h1FC0), 32'h100, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'hC0, 32'h0, 5'd0, 1'b0, 5'd7, 5'd8};
    bv[6]  = '{enc_b(3'b111, 5'd7, 5'd8, 13'h1FC0), 32'h100, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h110, 32'h0, 5'd0, 1'b0, 5'd7, 5'd8};
    bv[7]  = '{enc_b(3'b010, 5'd1, 5'd2, 13'd32), 32'h40, 32'd5, 32'd5, 1'b0, 32'h50, 32'h0, 5'd0, 1'b0, 5'd1, 5'd2};
    bv[8]  = '{enc_j(5'd1, 21'h100), 32'h20, 32'd0, 32'd0, 1'b1, 32'h120, 32'h30, 5'd1, 1'b1, 5'd0, 5'd0};
    bv[9]  = '{enc_j(5'd0, 21'h100), 32'h20, 32'd0, 32'd0, 1'b1, 32'h120, 32'h30, 5'd0, 1'b0, 5'd0, 5'd0};
    bv[10] = '{enc_jalr(5'd3, 5'd2, 12'h000), 32'h80, 32'h1003, 32'd0, 1'b1, 32'h1002, 32'h90, 5'd3, 1'b1, 5'd2, 5'd0};
    bv[11] = '{enc_jalr(5'd5, 5'd2, 12'hFFC), 32'h0, 32'h2000, 32'd0, 1'b1, 32'h1FFC, 32'h10, 5'd5, 1'b1, 5'd2, 5'd0};
    bv[12] = '{32'h0020_81B3, 32'h60, 32'd1, 32'd1, 1'b0, 32'h70, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0};
    bv[13] = '{enc_j(5'd2, 21'h1F_FFF8), 32'h100, 32'd0, 32'd0, 1'b1, 32'hF8, 32'h110, 5'd2, 1'b1, 5'd0, 5'd0};

    fv[0] = '{5'd7,  5'd7, 5'd7, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c_d3};
    fv[1] = '{5'd7,  5'd7, 5'd7, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c_d2};
    fv[2] = '{5'd0,  5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    fv[3] = '{5'd7,  5'd7, 5'd7, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, c_d1};
    fv[4] = '{5'd7,  5'd7, 5'd8, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c_d1};
    fv[5] = '{5'd7,  5'd8, 5'd8, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    fv[6] = '{5'd9,  5'd9, 5'd9, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c_d2};
    fv[7] = '{5'd9,  5'd9, 5'd9, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, c_d2};
    fv[8] = '{5'd31, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    fv[9] = '{5'd31, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, c_d3};

    sv[0] = '{1'b1, 5'd5,  3'd3, 5'd5,  1'b1};
    sv[1] = '{1'b1, 5'd0,  3'd3, 5'd5,  1'b0};
    sv[2] = '{1'b1, 5'd0,  3'd3, 5'd0,  1'b0};
    sv[3] = '{1'b0, 5'd5,  3'd3, 5'd5,  1'b0};
    sv[4] = '{1'b1, 5'd5,  3'd0, 5'd5,  1'b1};
    sv[5] = '{1'b1, 5'd12, 3'd5, 5'd13, 1'b0};
    sv[6] = '{1'b1, 5'd31, 3'd4, 5'd31, 1'b1};
    sv[7] = '{1'b1, 5'd9,  3'd1, 5'd9,  1'b1};

    rst = 1'b1; inst = c_nop; inst_pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    for (int k = 0; k < 6; k++) begin dc_src[k] = 5'd0; ex_src[k] = 5'd0; end
    lsu_ex_rd = 5'd0; lsu_ex_is_load = 1'b0;
    ixu1_wb_rd = 5'd0; ixu2_wb_rd = 5'd0; lsu_wb_rd = 5'd0;
    ixu1_wb_data = c_d1; ixu2_wb_data = c_d2; lsu_wb_data = c_d3;
    ixu1_wb_nop = 1'b1; ixu2_wb_nop = 1'b1; lsu_wb_nop = 1'b1; lsu_wb_is_load = 1'b0;

    // reset state
    do_reset();
    chk("rst stall", stall, 0);
    chk("rst rs1_out", rs1_out, 0);
    chk("rst rs2_out", rs2_out, 0);
    chk("rst ex_pc", ex_pc_out, 0);
    chk("rst rd_out", rd_out, 0);
    chk("rst ret_addr", ret_addr, 0);
    chk("rst wr_en", reg_file_wr_en, 0);
    chk("rst taken", branch_taken, 0);
    chk("rst new_pc", new_pc, 32'd16);
    chk("rst halt", halt_proc, 0);
    chk("rst fwd flags", {26'd0, f_flag}, 0);

    // forwarding table, applied to all six execute sources at once
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 6; k++) ex_src[k] = fv[i].s;
      ixu1_wb_rd = fv[i].rd1; ixu2_wb_rd = fv[i].rd2; lsu_wb_rd = fv[i].rd3;
      ixu1_wb_nop = fv[i].n1; ixu2_wb_nop = fv[i].n2; lsu_wb_nop = fv[i].n3;
      lsu_wb_is_load = fv[i].ld;
      #1;
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("fwd%0d src%0d flag", i, k), {31'd0, f_flag[k]}, {31'd0, fv[i].fwd});
        chk($sformatf("fwd%0d src%0d data", i, k), f_data[k], fv[i].data);
      end
    end
    for (int k = 0; k < 6; k++) ex_src[k] = 5'd0;
    ixu1_wb_nop = 1'b1; ixu2_wb_nop = 1'b1; lsu_wb_nop = 1'b1; lsu_wb_is_load = 1'b0;

    // stall table, one decode source non-zero at a time
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 6; k++) dc_src[k] = 5'd0;
      dc_src[sv[i].idx] = sv[i].src;
      lsu_ex_is_load = sv[i].ld; lsu_ex_rd = sv[i].exrd;
      #1;
      chk($sformatf("stall%0d", i), stall, sv[i].exp);
    end
    for (int k = 0; k < 6; k++) dc_src[k] = 5'd0;
    lsu_ex_is_load = 1'b0; lsu_ex_rd = 5'd0;

    // branch/jump table: each vector walks D then E after a reset
    for (int i = 0; i < 14; i++) begin
      do_reset();
      inst = bv[i].inst; inst_pc = bv[i].pc; rs1_data = bv[i].a; rs2_data = bv[i].b;
      tick();
      inst = c_nop; inst_pc = 32'd0;
      tick();
      chk($sformatf("br%0d taken", i), branch_taken, bv[i].tk);
      chk($sformatf("br%0d new_pc", i), new_pc, bv[i].npc);
      chk($sformatf("br%0d ret_addr", i), ret_addr, bv[i].ret);
      chk($sformatf("br%0d rd_out", i), rd_out, bv[i].rd);
      chk($sformatf("br%0d wr_en", i), reg_file_wr_en, bv[i].we);
      chk($sformatf("br%0d rs1_out", i), rs1_out, bv[i].r1);
      chk($sformatf("br%0d rs2_out", i), rs2_out, bv[i].r2);
      chk($sformatf("br%0d ex_pc", i), ex_pc_out, bv[i].pc);
    end
    rs1_data = 32'd0; rs2_data = 32'd0;

    // load-use on BRU decode source: D holds, E bubbles, then taken flush
    do_reset();
    inst = enc_b(3'b000, 5'd5, 5'd0, 13'd32); inst_pc = 32'h40;
    tick();
    inst = c_nop; inst_pc = 32'd0;
    lsu_ex_is_load = 1'b1; lsu_ex_rd = 5'd5;
    #1;
    chk("seqA stall D", stall, 1);
    tick();
    chk("seqA stall held", stall, 1);
    chk("seqA E bubble rs1", rs1_out, 0);
    chk("seqA E bubble taken", branch_taken, 0);
    lsu_ex_is_load = 1'b0; lsu_ex_rd = 5'd0;
    tick();
    chk("seqA E rs1", rs1_out, 5);
    chk("seqA E pc", ex_pc_out, 32'h40);
    chk("seqA taken", branch_taken, 1);
    chk("seqA new_pc", new_pc, 32'h60);
    inst = enc_j(5'd1, 21'h100); inst_pc = 32'h200;
    tick();
    inst = c_nop; inst_pc = 32'd0;
    chk("seqA flush taken", branch_taken, 0);
    chk("seqA flush wr_en", reg_file_wr_en, 0);
    tick();
    chk("seqA D flushed", branch_taken, 0);
    chk("seqA D flushed rd", rd_out, 0);

    // taken and stall in the same cycle: taken wins
    do_reset();
    inst = enc_b(3'b000, 5'd0, 5'd0, 13'd32); inst_pc = 32'h40;
    tick();
    inst = enc_b(3'b000, 5'd5, 5'd0, 13'd32); inst_pc = 32'h50;
    tick();
    inst = c_nop; inst_pc = 32'd0;
    lsu_ex_is_load = 1'b1; lsu_ex_rd = 5'd5;
    #1;
    chk("seqB stall", stall, 1);
    chk("seqB taken", branch_taken, 1);
    tick();
    lsu_ex_is_load = 1'b0; lsu_ex_rd = 5'd0;
    #1;
    chk("seqB after rs1", rs1_out, 0);
    chk("seqB after taken", branch_taken, 0);
    tick();
    chk("seqB D squashed", rs1_out, 0);

    // BRU operands taken from writeback forwarding
    do_reset();
    inst = enc_b(3'b000, 5'd5, 5'd6, 13'd32); inst_pc = 32'h40;
    tick();
    inst = c_nop; inst_pc = 32'd0;
    tick();
    rs1_data = 32'd3; rs2_data = 32'd9;
    #1;
    chk("seqC no fwd", branch_taken, 0);
    ixu1_wb_nop = 1'b0; ixu1_wb_rd = 5'd6; ixu1_wb_data = 32'd3;
    #1;
    chk("seqC fwd rs2 taken", branch_taken, 1);
    chk("seqC fwd new_pc", new_pc, 32'h60);
    lsu_wb_nop = 1'b0; lsu_wb_is_load = 1'b1; lsu_wb_rd = 5'd5; lsu_wb_data = 32'd7;
    #1;
    chk("seqC fwd rs1 not taken", branch_taken, 0);
    chk("seqC fwd new_pc nt", new_pc, 32'h50);
    ixu1_wb_nop = 1'b1; lsu_wb_nop = 1'b1; lsu_wb_is_load = 1'b0;
    ixu1_wb_data = c_d1; lsu_wb_data = c_d3; rs1_data = 32'd0; rs2_data = 32'd0;

    // ECALL / EBREAK halt for exactly their E cycle
    do_reset();
    inst = 32'h0000_0073; inst_pc = 32'h80;
    tick();
    inst = 32'h0010_0073; inst_pc = 32'h90;
    tick();
    inst = c_nop; inst_pc = 32'd0;
    chk("ecall halt", halt_proc, 1);
    chk("ecall pc", ex_pc_out, 32'h80);
    tick();
    chk("ebreak halt", halt_proc, 1);
    tick();
    chk("halt cleared", halt_proc, 0);

    // reset asserted mid-stream
    do_reset();
    inst = enc_j(5'd1, 21'h100); inst_pc = 32'h20;
    tick();
    inst = enc_jalr(5'd4, 5'd0, 12'h040); inst_pc = 32'h30;
    tick();
    chk("seqE pre wr_en", reg_file_wr_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; inst = c_nop; inst_pc = 32'd0;
    #1;
    chk("seqE rst taken", branch_taken, 0);
    chk("seqE rst new_pc", new_pc, 32'd16);
    chk("seqE rst rd", rd_out, 0);
    chk("seqE rst ret", ret_addr, 0);
    chk("seqE rst wr_en", reg_file_wr_en, 0);
    chk("seqE rst pc", ex_pc_out, 0);
    tick();
    chk("seqE D reset", branch_taken, 0);
    chk("seqE D reset pc", ex_pc_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
